uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_DIV, default 54, clocks per 16x oversample tick (bit period = 16*CLK_DIV clocks); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..64.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 rx_i  input  1  asynchronous serial line, idle high, 8 data bits, LSB first, 1 stop bit.
REQ-006 rdata_o  output  8  byte at FIFO head.
REQ-007 rvalid_o  output  1  FIFO non-empty.
REQ-008 rready_i  input  1  consumer accept; pop when rvalid_o & rready_i.
REQ-009 rcount_o  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 frame_err_o  output  1  one-cycle pulse: stop bit sampled low (or parity mismatch, REQ-030).
REQ-011 overrun_o  output  1  one-cycle pulse: completed byte dropped because FIFO full.

Function
REQ-012 rx_i SHALL pass a 2-flop synchronizer (reset value 1) before any use; latency 2 clocks.
REQ-013 Tick divider SHALL count 0..CLK_DIV-1, assert tick on CLK_DIV-1, and clear to 0 on the IDLE->START transition.
REQ-014 Tick counter (4 bit) SHALL increment per tick and wrap 15->0; cleared on every state entry.
REQ-015 States: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY per REQ-030).
REQ-016 IDLE: synchronized rx low -> START.
REQ-017 START: at tick count 7 (mid start bit) rx high -> IDLE (glitch, no flags); rx low -> DATA.
REQ-018 DATA: every 16th tick after mid-start, sample rx into shift register LSB first; after bit 7 -> STOP.
REQ-019 STOP: at 16th tick sample rx; high -> push byte, -> IDLE; low -> frame_err_o pulse, byte discarded, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until synchronized rx high, then -> IDLE; held-low break yields exactly one frame_err_o.
REQ-021 Push occurs in the cycle the stop bit is sampled; rvalid_o SHALL rise the following cycle.
REQ-022 FIFO: rdata_o SHALL show head entry combinationally from storage; order preserved.
REQ-023 Push when full and no pop in same cycle: byte dropped, overrun_o pulses, FIFO contents unchanged.
REQ-024 Push and pop same cycle when full: both accepted, occupancy stays FIFO_DEPTH, no overrun.
REQ-025 Push and pop same cycle when non-full non-empty: occupancy unchanged.
REQ-026 Pop when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-027 Receiver operation SHALL be independent of rready_i; no back-pressure on the line.

Reset
REQ-028 On rst_i: state IDLE, divider/tick/bit counters 0, synchronizer 1, FIFO empty; rvalid_o=0, rcount_o=0, frame_err_o=0, overrun_o=0, rdata_o=0.
REQ-029 rst_i mid-frame SHALL abort the frame with no push and no flag; reception restarts on next falling edge after reset release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples one even-parity bit at 16th tick; mismatch -> frame_err_o pulse, byte discarded, STOP still sampled then -> IDLE or WAIT_HIGH per stop value; frame = 11 bits.
REQ-031 UART_RX_PARITY_EN undefined: no PARITY state, frame = 10 bits, no parity logic present.

Verification (CLK_DIV=4, FIFO_DEPTH=4, bit period 64 clocks, parity off unless stated)
REQ-032 Send 0xA5, rready_i=0 -> rvalid_o=1, rdata_o=0xA5, rcount_o=1, no flags.
REQ-033 Send 0x01,0x02,0x03,0x04,0x05 with rready_i=0 -> rcount_o=4, overrun_o pulses once at fifth stop bit, pops return 01,02,03,04.
REQ-034 Send 0x3C with stop bit low, then line low 500 clocks, then high, then 0x7E -> one frame_err_o pulse, only 0x7E queued.
REQ-035 Low glitch of 20 clocks on idle line -> no push, no flags, state returns IDLE.
REQ-036 Assert rst_i at bit 4 of 0x55, release, send 0x99 -> FIFO holds only 0x99.
REQ-037 UART_RX_PARITY_EN: 0x03 with parity 0 -> queued; 0x03 with parity 1 -> frame_err_o pulse, nothing queued.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, 16x oversampling FSM, small receive FIFO.
// Latency: byte pushed in the cycle its stop bit is sampled; rvalid_o rises one cycle later.
// Backpressure: none on the line; a byte completed while the FIFO is full is dropped (overrun_o).
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLK_DIV    = 54,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   rcount_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0]    DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;
`endif

  state_t         r_state;
  state_t         w_next;
  logic           r_rx_meta;
  logic           r_rx_sync;
  logic           w_rx;
  logic [15:0]    r_div;
  logic           w_tick;
  logic [3:0]     r_tcnt;
  logic           w_sample_mid;
  logic           w_sample_bit;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;
  logic           w_shift_en;
  logic           w_push_req;
  logic           w_ferr;
  logic           r_ferr;
  logic           r_ovr;
`ifdef UART_RX_PARITY_EN
  logic           r_par_err;
`endif

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_pop;
  logic           w_full;
  logic           w_push;
  logic           w_ovr;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end
  assign w_rx = r_rx_sync;

  // Oversample divider, realigned to the falling edge when a frame starts.
  assign w_tick = (r_div == DIV_MAX);
  always_ff @(posedge clk_i) begin
    if (rst_i)                                   r_div <= '0;
    else if (r_state == S_IDLE && w_next == S_START) r_div <= '0;
    else if (w_tick)                             r_div <= '0;
    else                                         r_div <= r_div + 16'd1;
  end

  // Tick counter: restarts on every state entry so each state measures from its own start.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 r_tcnt <= '0;
    else if (w_next != r_state) r_tcnt <= '0;
    else if (w_tick)           r_tcnt <= r_tcnt + 4'd1;
  end
  assign w_sample_mid = w_tick && (r_tcnt == 4'd7);
  assign w_sample_bit = w_tick && (r_tcnt == 4'd15);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx) w_next = S_START;
      S_START:     if (w_sample_mid) w_next = w_rx ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (w_sample_bit && r_bitcnt == 3'd7) w_next = S_PARITY;
      S_PARITY:    if (w_sample_bit) w_next = S_STOP;
`else
      S_DATA:      if (w_sample_bit && r_bitcnt == 3'd7) w_next = S_STOP;
`endif
      S_STOP:      if (w_sample_bit) w_next = w_rx ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FSM outputs: shift strobe, push request and frame-error strobe.
  always_comb begin
    w_shift_en = (r_state == S_DATA) && w_sample_bit;
`ifdef UART_RX_PARITY_EN
    w_push_req = (r_state == S_STOP) && w_sample_bit && w_rx && !r_par_err;
    w_ferr     = ((r_state == S_STOP) && w_sample_bit && !w_rx) ||
                 ((r_state == S_PARITY) && w_sample_bit && (w_rx != ^r_shift));
`else
    w_push_req = (r_state == S_STOP) && w_sample_bit && w_rx;
    w_ferr     = (r_state == S_STOP) && w_sample_bit && !w_rx;
`endif
  end

  // Receive datapath: LSB-first shift register, bit counter, latched parity error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift   <= '0;
      r_bitcnt  <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      if (r_state == S_START) begin
        r_bitcnt  <= '0;
`ifdef UART_RX_PARITY_EN
        r_par_err <= 1'b0;
`endif
      end
      if (w_shift_en) begin
        r_shift  <= {w_rx, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (r_state == S_PARITY && w_sample_bit) r_par_err <= w_rx ^ (^r_shift);
`endif
    end
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO.
  assign w_pop  = rvalid_o && rready_i;
  assign w_full = (r_count == DEPTH_C);
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_ovr  = w_push_req && w_full && !w_pop;

  // FIFO storage, cleared on reset so rdata_o reads zero when empty after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Error flags registered into clean single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_ovr;
    end
  end

  assign rdata_o     = r_mem[r_rptr];
  assign rvalid_o    = (r_count != '0);
  assign rcount_o    = r_count;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames against a queue model.
module tb_uart_rx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int BIT     = 16 * CLK_DIV;
  localparam int GAP     = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rready;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] rcount;
  logic       ferr;
  logic       ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  byte unsigned q[$];

  uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .rdata_o(rdata), .rvalid_o(rvalid),
    .rready_i(rready), .rcount_o(rcount), .frame_err_o(ferr), .overrun_o(ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (ovr === 1'b1)  ovr_cnt  = ovr_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(BIT);
  endtask

  // Whole frame; low_after keeps the line low after the stop bit (break).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                            input int low_after);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_bad);
`else
    if (par_bad) $display("[TB] parity flip ignored, parity disabled");
`endif
    send_bit(stop);
    if (low_after > 0) begin
      rx = 1'b0;
      idle(low_after);
    end
    rx = 1'b1;
    idle(GAP);
  endtask

  task automatic pop_pulse();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx = 1'b1; rready = 1'b0;
    idle(3);
    rst = 1'b0;
    q.delete();
    idle(5);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rready = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(2);
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_tests++; if (rcount !== 3'd0) begin n_fail++; $display("FAIL reset_rcount: got %0d expected 0", rcount); end
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    n_tests++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
  endtask

  task automatic test_single();
    int f0, o0;
    do_reset();
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid: got %b expected 1", rvalid); end
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL single_rdata: got %h expected a5", rdata); end
    n_tests++; if (rcount !== 3'd1) begin n_fail++; $display("FAIL single_rcount: got %0d expected 1", rcount); end
    n_tests++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
      n_fail++; $display("FAIL single_flags: got ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_overrun();
    int f0, o0;
    do_reset();
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, 0);
    n_tests++; if (rcount !== 3'd4) begin n_fail++; $display("FAIL ovr_rcount: got %0d expected 4", rcount); end
    n_tests++; if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - o0); end
    n_tests++; if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL ovr_ferr: got %0d expected 0", ferr_cnt - f0); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rvalid !== 1'b1 || rdata !== 8'(i + 1)) begin
        n_fail++; $display("FAIL ovr_pop%0d: got v=%b d=%h expected v=1 d=%h", i, rvalid, rdata, 8'(i + 1)); end
      pop_pulse();
    end
    n_tests++; if (rvalid !== 1'b0 || rcount !== 3'd0) begin
      n_fail++; $display("FAIL ovr_drained: got v=%b cnt=%0d expected 0 0", rvalid, rcount); end
  endtask

  task automatic test_break();
    int f0, o0;
    do_reset();
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 500);
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    n_tests++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt - f0); end
    n_tests++; if (rcount !== 3'd1) begin n_fail++; $display("FAIL break_rcount: got %0d expected 1", rcount); end
    n_tests++; if (rdata !== 8'h7E) begin n_fail++; $display("FAIL break_rdata: got %h expected 7e", rdata); end
    n_tests++; if (ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL break_ovr: got %0d expected 0", ovr_cnt - o0); end
  endtask

  task automatic test_glitch();
    int f0, o0;
    do_reset();
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0; idle(20);
    rx = 1'b1; idle(150);
    n_tests++; if (rcount !== 3'd0 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_push: got cnt=%0d v=%b expected 0 0", rcount, rvalid); end
    n_tests++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
      n_fail++; $display("FAIL glitch_flags: got ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    n_tests++; if (rcount !== 3'd1 || rdata !== 8'h5A) begin
      n_fail++; $display("FAIL glitch_after: got cnt=%0d d=%h expected 1 5a", rcount, rdata); end
  endtask

  task automatic test_reset_midframe();
    int f0, o0;
    logic [7:0] d;
    do_reset();
    d = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    idle(BIT / 2);
    rst = 1'b1; rx = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(100);
    f0 = ferr_cnt; o0 = ovr_cnt;
    n_tests++; if (rcount !== 3'd0) begin n_fail++; $display("FAIL rstmid_empty: got %0d expected 0", rcount); end
    send_frame(8'h99, 1'b1, 1'b0, 0);
    n_tests++; if (rcount !== 3'd1 || rdata !== 8'h99) begin
      n_fail++; $display("FAIL rstmid_data: got cnt=%0d d=%h expected 1 99", rcount, rdata); end
    n_tests++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
      n_fail++; $display("FAIL rstmid_flags: got ferr %0d ovr %0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int f0;
    do_reset();
    f0 = ferr_cnt;
    send_frame(8'h03, 1'b1, 1'b0, 0);
    n_tests++; if (rcount !== 3'd1 || rdata !== 8'h03) begin
      n_fail++; $display("FAIL parity_good: got cnt=%0d d=%h expected 1 03", rcount, rdata); end
    send_frame(8'h03, 1'b1, 1'b1, 0);
    n_tests++; if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL parity_ferr: got %0d expected 1", ferr_cnt - f0); end
    n_tests++; if (rcount !== 3'd1) begin n_fail++; $display("FAIL parity_drop: got %0d expected 1", rcount); end
  endtask
`endif

  // Random frames and pops checked against a queue model of the FIFO.
  task automatic test_random();
    int f0, o0, exp_f, exp_o, npop;
    logic [7:0] d;
    logic stop, pbad;
    do_reset();
    f0 = ferr_cnt; o0 = ovr_cnt; exp_f = 0; exp_o = 0;
    for (int it = 0; it < 40; it++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pbad = 1'b0;
`ifdef UART_RX_PARITY_EN
      if (stop && $urandom_range(0, 7) == 0) pbad = 1'b1;
`endif
      send_frame(d, stop, pbad, 0);
      if (!stop || pbad)          exp_f++;
      else if (q.size() < DEPTH)  q.push_back(d);
      else                        exp_o++;
      n_tests++; if (rcount !== 3'(q.size())) begin
        n_fail++; $display("FAIL rand_count it%0d: got %0d expected %0d", it, rcount, q.size()); end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (q.size() > 0) begin
          n_tests++; if (rvalid !== 1'b1 || rdata !== q[0]) begin
            n_fail++; $display("FAIL rand_pop it%0d: got v=%b d=%h expected v=1 d=%h", it, rvalid, rdata, q[0]); end
          void'(q.pop_front());
        end else begin
          n_tests++; if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rand_empty it%0d: got v=%b expected 0", it, rvalid); end
        end
        pop_pulse();
      end
    end
    n_tests++; if (ferr_cnt - f0 != exp_f) begin
      n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_f); end
    n_tests++; if (ovr_cnt - o0 != exp_o) begin
      n_fail++; $display("FAIL rand_ovr: got %0d expected %0d", ovr_cnt - o0, exp_o); end
    n_tests++; if (rcount !== 3'(q.size())) begin
      n_fail++; $display("FAIL rand_final_count: got %0d expected %0d", rcount, q.size()); end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rready = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_break();
    test_glitch();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
